// File: rtl/pins_uart_tx.sv
// pins_uart_tx: logs every change of the 8-bit output port into a FIFO
// and sends each logged value as an 8N1 serial frame (LSB first).
//
// Ports:
//   Clk        system clock, rising edge
//   Rst        synchronous reset, active-high
//   Pins_in    output port value being watched
//   Tx         serial line, idles high (registered)
//   Busy       high whenever a frame is in progress (registered)
//   Overflow   sticky, set when a change is dropped on a full FIFO
//   Fifo_count entries currently held in the FIFO
module pins_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [7:0]       Pins_in,
  output logic             Tx,
  output logic             Busy,
  output logic             Overflow,
  output logic [CNT_W-1:0] Fifo_count
);

  localparam int PTR_W =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_LAST =
    16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [15:0]      baud;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       prev_pins;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic change;
  logic empty;
  logic full;
  logic bit_end;
  logic pop;
  logic push;

  assign change  = (Pins_in != prev_pins);
  assign empty   = (Fifo_count == '0);
  assign full    = (Fifo_count == FULL_CNT);
  assign bit_end = (baud == BAUD_LAST);

  // Pops only from IDLE or at the very last edge of a stop bit,
  // which gives back-to-back frames without an idle gap.
  assign pop = !empty &&
    ((state == IDLE) ||
     ((state == STOP) && bit_end));

  // A full FIFO still accepts a push if a pop frees a slot
  // at the same edge.
  assign push = change && (!full || pop);

  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      mem[wr_ptr] <= Pins_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev_pins  <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_count <= '0;
      Overflow   <= 1'b0;
    end else begin
      if (change) begin
        prev_pins <= Pins_in;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (change && !push) begin
        Overflow <= 1'b1;
      end
      Fifo_count <= Fifo_count
                  + CNT_W'(push)
                  - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      Tx      <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Tx   <= 1'b1;
          Busy <= 1'b0;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
            Tx    <= 1'b0;
            Busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            Tx      <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              Tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              Tx      <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              Tx    <= 1'b0;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pins_uart_tx.sv
// tb_pins_uart_tx: directed stimulus for pins_uart_tx with a
// frame-timeline model compared against the DUT every cycle.
module tb_pins_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FRAME = 10 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pins = 8'h00;
  logic          tx;
  logic          busy;
  logic          ovf;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  pins_uart_tx #(
    .CLK_DIV   (D),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Pins_in   (pins),
    .Tx        (tx),
    .Busy      (busy),
    .Overflow  (ovf),
    .Fifo_count(cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: a queue of logged values plus the position
  // inside the frame currently on the line.
  logic [7:0] mq[$];
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_byte = 8'h00;
  bit         m_act  = 1'b0;
  int         m_t    = 0;
  bit         m_ovf  = 1'b0;
  bit         armed  = 1'b0;

  initial begin : model
    bit pop_now;
    bit was_full;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_prev = 8'h00;
        m_act  = 1'b0;
        m_t    = 0;
        m_ovf  = 1'b0;
      end else begin
        pop_now  = (mq.size() != 0) &&
                   (!m_act || m_t == FRAME - 1);
        was_full = (mq.size() == DEPTH);
        if (pop_now) begin
          m_byte = mq.pop_front();
          m_act  = 1'b1;
          m_t    = 0;
        end else if (m_act && m_t == FRAME - 1) begin
          m_act = 1'b0;
        end else if (m_act) begin
          m_t++;
        end
        if (pins != m_prev) begin
          if (!was_full || pop_now) mq.push_back(pins);
          else m_ovf = 1'b1;
          m_prev = pins;
        end
      end
    end
  end

  function automatic logic exp_tx();
    logic [7:0] b;
    b = m_byte;
    if (!m_act) return 1'b1;
    if (m_t < D) return 1'b0;
    if (m_t >= 9 * D) return 1'b1;
    return b[(m_t / D) - 1];
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (armed) begin
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("busy", {31'b0, busy}, {31'b0, m_act});
        check("count", {29'b0, cnt}, mq.size());
        check("overflow", {31'b0, ovf}, {31'b0, m_ovf});
      end
    end
  end

  logic rec_tx[$];
  logic rec_busy[$];
  bit   rec_en = 1'b0;
  int   peak   = 0;

  initial begin : recorder
    forever begin
      @(negedge clk);
      if (rec_en) begin
        rec_tx.push_back(tx);
        rec_busy.push_back(busy);
        if (int'(cnt) > peak) peak = int'(cnt);
      end
    end
  end

  task automatic rec_start();
    rec_tx.delete();
    rec_busy.delete();
    peak   = 0;
    rec_en = 1'b1;
  endtask

  function automatic int busy_total();
    int n = 0;
    foreach (rec_busy[i]) if (rec_busy[i]) n++;
    return n;
  endfunction

  function automatic logic rec_at(input int idx);
    if (idx < 0 || idx >= rec_tx.size()) return 1'bx;
    return rec_tx[idx];
  endfunction

  // Frames are decoded mid-bit starting at the first busy cycle.
  task automatic check_frames(input string tag,
                              input int n,
                              input logic [39:0] exp);
    int first;
    logic [7:0] b;
    int base;
    first = -1;
    foreach (rec_busy[i])
      if (rec_busy[i] && first < 0) first = i;
    check({tag, "_found"}, {31'b0, first >= 0}, 1);
    for (int j = 0; j < n; j++) begin
      base = first + j * FRAME;
      for (int k = 0; k < 8; k++)
        b[k] = rec_at(base + (k + 1) * D + D / 2);
      check($sformatf("%s_start%0d", tag, j),
            {31'b0, rec_at(base + D / 2)}, 0);
      check($sformatf("%s_byte%0d", tag, j),
            {24'b0, b}, {24'b0, exp[j*8 +: 8]});
      check($sformatf("%s_stop%0d", tag, j),
            {31'b0, rec_at(base + 9 * D + D / 2)}, 1);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    pins = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    @(negedge clk);
    armed = 1'b1;
    check("rst_tx", {31'b0, tx}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_count", {29'b0, cnt}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    @(negedge clk);

    // single frame of A5
    rst  = 1'b0;
    pins = 8'hA5;
    rec_start();
    repeat (60) @(negedge clk);
    rec_en = 1'b0;
    check("t1_busy_cycles", busy_total(), 40);
    check_frames("t1", 1, 40'hA5);
    check("t1_count", {29'b0, cnt}, 0);

    // constant zero: nothing to log
    do_reset();
    rec_start();
    repeat (100) @(negedge clk);
    rec_en = 1'b0;
    check("t2_busy_cycles", busy_total(), 0);
    check("t2_tx", {31'b0, tx}, 1);

    // three consecutive changes, back-to-back frames
    do_reset();
    rec_start();
    pins = 8'h01;
    @(negedge clk);
    pins = 8'h02;
    @(negedge clk);
    pins = 8'h03;
    repeat (140) @(negedge clk);
    rec_en = 1'b0;
    check("t3_busy_cycles", busy_total(), 120);
    check_frames("t3", 3, 40'h00_00_03_02_01);
    check("t3_ovf", {31'b0, ovf}, 0);

    // six changes: one popped, four buffered, one dropped
    do_reset();
    rec_start();
    for (int v = 8'h11; v <= 8'h16; v++) begin
      pins = 8'(v);
      @(negedge clk);
    end
    repeat (230) @(negedge clk);
    rec_en = 1'b0;
    check("t4_busy_cycles", busy_total(), 200);
    check_frames("t4", 5, 40'h15_14_13_12_11);
    check("t4_ovf", {31'b0, ovf}, 1);
    check("t4_peak", peak, 4);

    // reset in the middle of a data bit with two queued
    do_reset();
    pins = 8'h21;
    @(negedge clk);
    pins = 8'h22;
    @(negedge clk);
    pins = 8'h23;
    repeat (8) @(negedge clk);
    check("t5_count_pre", {29'b0, cnt}, 2);
    check("t5_busy_pre", {31'b0, busy}, 1);
    rst  = 1'b1;
    pins = 8'h00;
    @(negedge clk);
    check("t5_tx", {31'b0, tx}, 1);
    check("t5_busy", {31'b0, busy}, 0);
    check("t5_count", {29'b0, cnt}, 0);
    check("t5_ovf", {31'b0, ovf}, 0);
    rst = 1'b0;
    rec_start();
    repeat (100) @(negedge clk);
    rec_en = 1'b0;
    check("t5_busy_cycles", busy_total(), 0);

    // full FIFO, change on the last stop-bit edge
    do_reset();
    for (int v = 8'h31; v <= 8'h35; v++) begin
      pins = 8'(v);
      @(negedge clk);
    end
    repeat (36) @(negedge clk);
    check("t6_count_pre", {29'b0, cnt}, 4);
    pins = 8'h36;
    @(negedge clk);
    check("t6_count", {29'b0, cnt}, 4);
    check("t6_ovf", {31'b0, ovf}, 0);
    check("t6_tx_start", {31'b0, tx}, 0);
    check("t6_busy", {31'b0, busy}, 1);
    repeat (5 * FRAME + 20) @(negedge clk);
    check("t6_count_end", {29'b0, cnt}, 0);
    check("t6_ovf_end", {31'b0, ovf}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
